pcie_x1_top_evt_sync: RTL and testbench



---
 rtl/pcie_x1_top_sync_pkg.sv | 18 +
 rtl/pcie_x1_top_sync_chain.sv | 25 ++
 rtl/pcie_x1_top_evt_sync.sv | 150 +++++++++++++++
 tb/tb_pcie_x1_top_evt_sync.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_x1_top_sync_pkg.sv
// Shared definitions for the PCIe x1 event synchronizer: channel state encoding
// and the minimum synchronizer depth.
package pcie_x1_top_sync_pkg;

    localparam int   SYNC_STAGES_MIN = 2;
    localparam logic STATE_IDLE      = 1'b0;
    localparam logic STATE_WAIT      = 1'b1;

    typedef enum logic {
        ST_IDLE = STATE_IDLE,
        ST_WAIT = STATE_WAIT
    } chan_state_e;

    function automatic bit sync_stages_ok(input int stages);
        return stages >= SYNC_STAGES_MIN;
    endfunction

endpackage

// File: rtl/pcie_x1_top_sync_chain.sv
// N-flop multi-bit synchronizer with asynchronous active-low reset; each bit
// is an independent level crossing.
module pcie_x1_top_sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/pcie_x1_top_evt_sync.sv
// Multi-channel event-pulse synchronizer f_clk -> s_clk using a toggle
// request/acknowledge handshake with a saturating per-channel pending counter.
module pcie_x1_top_evt_sync
    import pcie_x1_top_sync_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             f_clk,
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_fclk,
    input  logic [WIDTH-1:0] ovf_clr,
    output logic [WIDTH-1:0] out_sclk,
    output logic [WIDTH-1:0] busy_fclk,
    output logic [WIDTH-1:0] ovf_fclk
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("pcie_x1_top_evt_sync: SYNC_STAGES must be at least SYNC_STAGES_MIN");
    end

    logic [WIDTH-1:0] w_req_t;
    logic [WIDTH-1:0] w_s_sync;
    logic [WIDTH-1:0] w_f_ack;
    logic [WIDTH-1:0] r_s_prev;
    logic [WIDTH-1:0] r_out;

    // ---------------------------------------------------------------- f_clk side
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        chan_state_e      r_state;
        chan_state_e      w_state_next;
        logic [CNT_W-1:0] r_pend;
        logic [CNT_W-1:0] w_pend_next;
        logic             r_req_t;
        logic             w_req_t_next;
        logic             r_ovf;
        logic             w_ovf_next;
        logic             r_busy;
        logic             w_busy_next;
        logic             w_inc;
        logic             w_launch;
        logic             w_drop;

        always_comb begin
            w_state_next = r_state;
            w_pend_next  = r_pend;
            w_req_t_next = r_req_t;
            w_ovf_next   = r_ovf;
            w_launch     = 1'b0;
            w_drop       = 1'b0;
            w_inc        = in_fclk[gi];

            case (r_state)
                ST_IDLE: begin
                    if ((r_pend != '0) || w_inc) begin
                        w_launch     = 1'b1;
                        w_req_t_next = ~r_req_t;
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_f_ack[gi] == r_req_t) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase

            // A fresh event in IDLE with nothing queued launches directly, so
            // the counter only moves when exactly one of inc/launch is active.
            if (w_inc && !w_launch) begin
                if (r_pend == PEND_MAX) begin
                    w_drop = 1'b1;
                end else begin
                    w_pend_next = r_pend + 1'b1;
                end
            end else if (!w_inc && w_launch) begin
                w_pend_next = r_pend - 1'b1;
            end

            if (w_drop) begin
                w_ovf_next = 1'b1;
            end else if (ovf_clr[gi]) begin
                w_ovf_next = 1'b0;
            end

            w_busy_next = (w_state_next == ST_WAIT) || (w_pend_next != '0);
        end

        always_ff @(posedge f_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_pend  <= '0;
                r_req_t <= 1'b0;
                r_ovf   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_pend  <= w_pend_next;
                r_req_t <= w_req_t_next;
                r_ovf   <= w_ovf_next;
                r_busy  <= w_busy_next;
            end
        end

        assign w_req_t[gi]   = r_req_t;
        assign busy_fclk[gi] = r_busy;
        assign ovf_fclk[gi]  = r_ovf;
    end

    // ---------------------------------------------------------------- s_clk side
    pcie_x1_top_sync_chain #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_req_sync (
        .clk   (s_clk),
        .rst_n (rst_n),
        .i_d   (w_req_t),
        .o_q   (w_s_sync)
    );

    // The delayed copy of the synchronized toggle doubles as the acknowledge,
    // so ack_t flips on the same edge that raises out_sclk.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_prev <= '0;
            r_out    <= '0;
        end else begin
            r_s_prev <= w_s_sync;
            r_out    <= w_s_sync ^ r_s_prev;
        end
    end

    assign out_sclk = r_out;

    pcie_x1_top_sync_chain #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (f_clk),
        .rst_n (rst_n),
        .i_d   (r_s_prev),
        .o_q   (w_f_ack)
    );

endmodule

// File: tb/tb_pcie_x1_top_evt_sync.sv
// Scoreboard bench for pcie_x1_top_evt_sync: every accepted event queues one
// expected out_sclk pulse; a monitor on s_clk pops one token per observed pulse.
`timescale 1ns/1ps
module tb_pcie_x1_top_evt_sync;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int CNTW = 2;
    // One event in flight plus a full pending counter.
    localparam int CAP  = 1 + ((1 << CNTW) - 1);

    logic            f_clk = 1'b0;
    logic            s_clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  in_fclk;
    logic [NCH-1:0]  ovf_clr;
    logic [NCH-1:0]  out_sclk;
    logic [NCH-1:0]  busy_fclk;
    logic [NCH-1:0]  ovf_fclk;

    int tf_half = 2;
    int ts_half = 8;

    // f edges always land on even ns, s edges on odd ns, so they never coincide.
    initial forever #(tf_half) f_clk = ~f_clk;
    initial begin
        #1;
        forever #(ts_half) s_clk = ~s_clk;
    end

    pcie_x1_top_evt_sync #(
        .WIDTH       (NCH),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNTW)
    ) dut (
        .f_clk     (f_clk),
        .s_clk     (s_clk),
        .rst_n     (rst_n),
        .in_fclk   (in_fclk),
        .ovf_clr   (ovf_clr),
        .out_sclk  (out_sclk),
        .busy_fclk (busy_fclk),
        .ovf_fclk  (ovf_fclk)
    );

    typedef struct packed {
        logic [31:0]    id;
        logic [NCH-1:0] together;
    } tok_t;

    tok_t     exp_q[NCH][$];
    int       edge_log[NCH][$];
    int       pulse_cnt[NCH];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       s_edge_cnt = 0;
    int       tok_id = 0;
    int       m_cnt[NCH];
    logic [NCH-1:0] m_ovf;
    logic [NCH-1:0] exp_busy;

    initial forever begin
        @(posedge s_clk);
        s_edge_cnt++;
    end

    // Monitor: one token per pulse, pulses one s_clk wide, grouped channels together.
    initial begin
        logic [NCH-1:0] prev;
        tok_t           t;
        prev = '0;
        forever begin
            @(negedge s_clk);
            if (rst_n) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (out_sclk[ch]) begin
                        n_checks++;
                        if (prev[ch]) begin
                            n_fail++;
                            $display("FAIL pulse_width ch%0d: out_sclk high 2 consecutive s_clk cycles, required 1", ch);
                        end else if (exp_q[ch].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse ch%0d: got pulse at s edge %0d, required none", ch, s_edge_cnt);
                        end else begin
                            t = exp_q[ch].pop_front();
                            if ((t.together != '0) && ((out_sclk & t.together) !== t.together)) begin
                                n_fail++;
                                $display("FAIL same_cycle ch%0d tok%0d: out_sclk=%b, required bits %b set", ch, t.id, out_sclk, t.together);
                            end
                        end
                        pulse_cnt[ch]++;
                        edge_log[ch].push_back(s_edge_cnt);
                    end
                end
                prev = out_sclk;
            end else begin
                prev = '0;
            end
        end
    end

    function automatic bit q_empty();
        for (int ch = 0; ch < NCH; ch++) begin
            if (exp_q[ch].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int total_pulses();
        int s;
        s = 0;
        for (int ch = 0; ch < NCH; ch++) s += pulse_cnt[ch];
        return s;
    endfunction

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_status();
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (ovf_fclk[ch] !== m_ovf[ch]) begin
                n_fail++;
                $display("FAIL ovf_fclk ch%0d: got %b, required %b", ch, ovf_fclk[ch], m_ovf[ch]);
            end
            if (exp_busy[ch]) begin
                n_checks++;
                if (busy_fclk[ch] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_fclk ch%0d: got %b, required 1", ch, busy_fclk[ch]);
                end
            end
        end
    endtask

    // One f_clk cycle of stimulus. The accept/drop model assumes either at most
    // CAP events per quiet period, or a burst shorter than one handshake round trip.
    task automatic drive(input logic [NCH-1:0] ev, input logic [NCH-1:0] clr,
                         input logic [NCH-1:0] tog);
        logic drop;
        tok_t t;
        @(negedge f_clk);
        check_status();
        in_fclk = ev;
        ovf_clr = clr;
        for (int ch = 0; ch < NCH; ch++) begin
            drop = 1'b0;
            if (ev[ch]) begin
                if (m_cnt[ch] < CAP) begin
                    m_cnt[ch]++;
                    t.id       = tok_id;
                    t.together = tog;
                    tok_id++;
                    exp_q[ch].push_back(t);
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop)            m_ovf[ch] = 1'b1;
            else if (clr[ch])    m_ovf[ch] = 1'b0;
            exp_busy[ch] = ev[ch];
        end
    endtask

    task automatic wait_idle(input string what);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge f_clk);
            if (q_empty() && (busy_fclk == '0)) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_%s: got busy=%b pending=%0d/%0d/%0d/%0d, required idle", what,
                     busy_fclk, exp_q[0].size(), exp_q[1].size(), exp_q[2].size(), exp_q[3].size());
        end
        for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
        exp_busy = '0;
        check_status();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int launch_edge;
        int p0;
        int gap;
        int min_gap;
        int n_ev;
        int n_gap;

        rst_n    = 1'b0;
        in_fclk  = '0;
        ovf_clr  = '0;
        m_ovf    = '0;
        exp_busy = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch]     = 0;
            pulse_cnt[ch] = 0;
        end

        repeat (4) @(negedge f_clk);
        check_int("reset_out_sclk", int'(out_sclk), 0);
        check_int("reset_busy_fclk", int'(busy_fclk), 0);
        check_int("reset_ovf_fclk", int'(ovf_fclk), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge f_clk);

        // Single pulse, fast f_clk / slow s_clk.
        p0 = pulse_cnt[0];
        drive(4'b0001, '0, '0);
        @(posedge f_clk);
        launch_edge = s_edge_cnt;
        drive('0, '0, '0);
        wait_idle("single");
        check_int("single_count", pulse_cnt[0] - p0, 1);
        if (edge_log[0].size() > 0) begin
            n_checks++;
            if ((edge_log[0][$] - launch_edge) < SYNC + 1 || (edge_log[0][$] - launch_edge) > SYNC + 2) begin
                n_fail++;
                $display("FAIL single_latency: got %0d s edges, required %0d..%0d",
                         edge_log[0][$] - launch_edge, SYNC + 1, SYNC + 2);
            end
        end

        // Burst filling the pending counter exactly: no overflow.
        p0 = pulse_cnt[1];
        repeat (CAP) drive(4'b0010, '0, '0);
        drive('0, '0, '0);
        wait_idle("burst");
        check_int("burst_count", pulse_cnt[1] - p0, CAP);

        // Overflow: 6-cycle burst, then clear, then clear coinciding with a drop.
        p0 = pulse_cnt[2];
        repeat (6) drive(4'b0100, '0, '0);
        drive('0, '0, '0);
        wait_idle("ovf_burst");
        check_int("ovf_count", pulse_cnt[2] - p0, CAP);
        drive('0, 4'b0100, '0);
        drive('0, '0, '0);
        for (int i = 0; i < 6; i++) drive(4'b0100, (i == 5) ? 4'b0100 : 4'b0000, '0);
        drive('0, '0, '0);
        wait_idle("ovf_set_wins");
        drive('0, 4'b0100, '0);
        drive('0, '0, '0);

        // Channels 0 and 3 launched together must deliver in the same s_clk cycle.
        drive(4'b1001, '0, 4'b1001);
        drive('0, '0, '0);
        check_int("indep_busy_ch1_ch2", int'(busy_fclk[2:1]), 0);
        wait_idle("indep");

        // Reset while WAIT with two events pending: everything is discarded.
        repeat (3) drive(4'b0010, '0, '0);
        drive('0, '0, '0);
        @(negedge f_clk);
        rst_n = 1'b0;
        #1;
        check_int("rst_mid_out_sclk", int'(out_sclk), 0);
        check_int("rst_mid_busy_fclk", int'(busy_fclk), 0);
        check_int("rst_mid_ovf_fclk", int'(ovf_fclk), 0);
        for (int ch = 0; ch < NCH; ch++) begin
            exp_q[ch].delete();
            m_cnt[ch] = 0;
        end
        m_ovf    = '0;
        exp_busy = '0;
        repeat (3) @(negedge f_clk);
        rst_n = 1'b1;
        p0 = total_pulses();
        repeat (20) @(negedge s_clk);
        check_int("rst_no_pulse_after", total_pulses() - p0, 0);
        wait_idle("after_reset");

        // Reverse ratio: slow f_clk, fast s_clk.
        tf_half = 8;
        ts_half = 2;
        repeat (4) @(negedge f_clk);
        p0 = pulse_cnt[0];
        drive(4'b0001, '0, '0);
        drive('0, '0, '0);
        wait_idle("rev_single");
        check_int("rev_single_count", pulse_cnt[0] - p0, 1);
        drive(4'b0001, '0, '0);
        drive(4'b0001, '0, '0);
        drive('0, '0, '0);
        wait_idle("rev_queued");
        check_int("rev_queued_count", pulse_cnt[0] - p0, 3);
        // Second launch must wait for the full handshake round trip.
        min_gap = (3 * 2 * tf_half + 2 * 2 * ts_half) / (2 * ts_half);
        if (edge_log[0].size() >= 2) begin
            gap = edge_log[0][$] - edge_log[0][edge_log[0].size() - 2];
            n_checks++;
            if (gap < min_gap) begin
                n_fail++;
                $display("FAIL rev_spacing: got %0d s edges between pulses, required >= %0d", gap, min_gap);
            end
        end

        // Randomized episodes at random clock ratios; at most CAP events per channel each.
        for (int ep = 0; ep < 24; ep++) begin
            tf_half = 2 * int'($urandom_range(1, 4));
            ts_half = 2 * int'($urandom_range(1, 4));
            repeat (3) @(negedge f_clk);
            n_ev = int'($urandom_range(1, CAP));
            for (int j = 0; j < n_ev; j++) begin
                drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), '0);
                n_gap = int'($urandom_range(0, 2));
                repeat (n_gap) drive('0, '0, '0);
            end
            drive('0, '0, '0);
            wait_idle("random");
        end

        repeat (50) @(negedge s_clk);
        check_int("final_queues_empty", int'(q_empty()), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
